// File: rtl/viterbi_tb_ctrl.sv
// Viterbi backend sequencer: minimum path-metric scan followed by survivor traceback.
// Latency: done pulses word_num+POS_num+2 cycles after the cycle that samples start.
// Backpressure: none; start is ignored while busy, abort cancels any pass synchronously.
module viterbi_tb_ctrl #(
  parameter int word_num     = 16,
  parameter int word_num_bit = 4,
  parameter int p_size       = 32,
  parameter int POS_num      = 11,
  parameter int POS_num_bit  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [word_num_bit-1:0]           key_i,
  input  logic [p_size-1:0]                 metric_i,
  input  logic                              dec_i,
  output logic                              RW_Key_reg,
  output logic [word_num_bit-1:0]           key_Key_reg,
  output logic                              decrement_enable,
  output logic [POS_num_bit+word_num_bit-1:0] surv_addr_o,
  output logic                              bit_o,
  output logic                              bit_valid_o,
  output logic [word_num_bit-1:0]           best_state_o,
  output logic [POS_num-1:0]                decoded_o,
  output logic                              busy,
  output logic                              done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_TRACE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Scan starts at the highest state index and counts down to 0.
  localparam logic [word_num_bit-1:0] KEY_TOP = word_num_bit'(word_num - 1);
  // Traceback starts at the deepest stage and walks back to stage 0.
  localparam logic [POS_num_bit-1:0]  POS_TOP = POS_num_bit'(POS_num - 1);

  state_t                   state;
  state_t                   state_nxt;

  // Set in LOAD so the first scanned metric seeds the running minimum.
  logic                     first_cmp;
  logic [p_size-1:0]        min_val;
  logic [word_num_bit-1:0]  min_idx;

  // Traceback cursor: current trellis state and stage index.
  logic [word_num_bit-1:0]  trace_state;
  logic [POS_num_bit-1:0]   pos;

  // Result of this cycle's compare, including the key_i==0 compare.
  logic                     take;
  logic [p_size-1:0]        scan_val;
  logic [word_num_bit-1:0]  scan_idx;

  // Scanning downward and replacing on <= leaves the lowest index on ties.
  always_comb begin
    take     = first_cmp || (metric_i <= min_val);
    scan_val = take ? metric_i : min_val;
    scan_idx = take ? key_i    : min_idx;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides everything, including start in IDLE.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_LOAD;
        ST_LOAD:  state_nxt = ST_SCAN;
        ST_SCAN:  if (key_i == '0) state_nxt = ST_TRACE;
        ST_TRACE: if (pos == '0) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output decode from state (and key_i for the decrement strobe); abort silences strobes.
  always_comb begin
    RW_Key_reg       = 1'b0;
    key_Key_reg      = '0;
    decrement_enable = 1'b0;
    surv_addr_o      = '0;
    bit_o            = 1'b0;
    bit_valid_o      = 1'b0;
    done             = 1'b0;
    busy             = (state != ST_IDLE);
    case (state)
      ST_LOAD: begin
        if (!abort) begin
          RW_Key_reg  = 1'b1;
          key_Key_reg = KEY_TOP;
        end
      end
      ST_SCAN: begin
        if (!abort && (key_i != '0)) begin
          decrement_enable = 1'b1;
        end
      end
      ST_TRACE: begin
        if (!abort) begin
          surv_addr_o = {pos, trace_state};
          bit_o       = trace_state[0];
          bit_valid_o = 1'b1;
        end
      end
      ST_DONE: begin
        done = !abort;
      end
      default: begin
        busy = (state != ST_IDLE);
      end
    endcase
  end

  // Datapath: minimum tracking, traceback cursor and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_cmp    <= 1'b0;
      min_val      <= '0;
      min_idx      <= '0;
      trace_state  <= '0;
      pos          <= '0;
      best_state_o <= '0;
      decoded_o    <= '0;
    end else if (!abort) begin
      case (state)
        ST_LOAD: begin
          first_cmp <= 1'b1;
        end
        ST_SCAN: begin
          first_cmp <= 1'b0;
          min_val   <= scan_val;
          min_idx   <= scan_idx;
          // The final compare feeds the traceback start directly.
          if (key_i == '0) begin
            best_state_o <= scan_idx;
            trace_state  <= scan_idx;
            pos          <= POS_TOP;
          end
        end
        ST_TRACE: begin
          for (int p = 0; p < POS_num; p++) begin
            if (pos == POS_num_bit'(p)) begin
              decoded_o[p] <= trace_state[0];
            end
          end
          trace_state <= {dec_i, trace_state[word_num_bit-1:1]};
          pos         <= pos - 1'b1;
        end
        default: begin
          first_cmp <= first_cmp;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Bench for viterbi_tb_ctrl: external key register, metric and survivor memories,
// and an argmin/traceback model checked against the DUT on every cycle of each pass.
module tb_viterbi_tb_ctrl;

  localparam int WN = 16;
  localparam int WB = 4;
  localparam int PS = 32;
  localparam int PN = 11;
  localparam int PB = 4;
  localparam int AW = PB + WB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WB-1:0] key_i;
  logic [PS-1:0] metric_i;
  logic          dec_i;
  logic          RW_Key_reg;
  logic [WB-1:0] key_Key_reg;
  logic          decrement_enable;
  logic [AW-1:0] surv_addr_o;
  logic          bit_o;
  logic          bit_valid_o;
  logic [WB-1:0] best_state_o;
  logic [PN-1:0] decoded_o;
  logic          busy;
  logic          done;

  logic [PS-1:0] metric_mem [WN];
  logic          surv_mem [1 << AW];

  int checks = 0;
  int errors = 0;

  int            exp_best;
  logic [PN-1:0] exp_dec;
  logic [AW-1:0] exp_addr [PN];
  logic          exp_bit [PN];
  int            prev_best = 0;
  logic [PN-1:0] prev_dec = '0;

  always #5 clk = ~clk;

  viterbi_tb_ctrl #(
    .word_num(WN), .word_num_bit(WB), .p_size(PS), .POS_num(PN), .POS_num_bit(PB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key_i(key_i), .metric_i(metric_i), .dec_i(dec_i),
    .RW_Key_reg(RW_Key_reg), .key_Key_reg(key_Key_reg),
    .decrement_enable(decrement_enable), .surv_addr_o(surv_addr_o),
    .bit_o(bit_o), .bit_valid_o(bit_valid_o), .best_state_o(best_state_o),
    .decoded_o(decoded_o), .busy(busy), .done(done)
  );

  // External key register: load wins over decrement.
  always @(posedge clk or negedge reset) begin
    if (!reset) key_i <= '0;
    else if (RW_Key_reg) key_i <= key_Key_reg;
    else if (decrement_enable) key_i <= key_i - 1'b1;
  end

  assign metric_i = metric_mem[key_i];
  assign dec_i    = surv_mem[surv_addr_o];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_bit_valid"}, 64'(bit_valid_o), 64'd0);
    chk({tag, "_bit"}, 64'(bit_o), 64'd0);
    chk({tag, "_best"}, 64'(best_state_o), 64'd0);
    chk({tag, "_decoded"}, 64'(decoded_o), 64'd0);
    chk({tag, "_rw"}, 64'(RW_Key_reg), 64'd0);
    chk({tag, "_key_load"}, 64'(key_Key_reg), 64'd0);
    chk({tag, "_decr"}, 64'(decrement_enable), 64'd0);
    chk({tag, "_surv_addr"}, 64'(surv_addr_o), 64'd0);
  endtask

  // Reference: lowest-index unsigned argmin, then walk the trellis backward.
  task automatic build_model();
    logic [PS-1:0] bm;
    logic [WB-1:0] st;
    logic [AW-1:0] a;
    int            p;
    logic [31:0]   pv;
    exp_best = 0;
    bm = metric_mem[0];
    for (int i = 1; i < WN; i++) begin
      if (metric_mem[i] < bm) begin
        bm = metric_mem[i];
        exp_best = i;
      end
    end
    pv = 32'(exp_best);
    st = pv[WB-1:0];
    exp_dec = '0;
    for (int k = 0; k < PN; k++) begin
      p = PN - 1 - k;
      pv = 32'(p);
      a = {pv[PB-1:0], st};
      exp_addr[k] = a;
      exp_bit[k] = st[0];
      exp_dec[p] = st[0];
      st = {surv_mem[a], st[WB-1:1]};
    end
  endtask

  // One decode pass from the current (mid-cycle, IDLE) time. Nonzero arguments
  // select the cycle (1 = LOAD) in which abort, reset or a stray start occur.
  task automatic run_pass(input int abort_c, input int reset_c, input int bstart_c);
    int   rw_n = 0;
    int   de_n = 0;
    int   bv_n = 0;
    int   done_at = 0;
    logic ab, e_rw, e_de, e_bv, e_bit, e_done, e_busy;
    logic [WB-1:0] e_key;
    logic [AW-1:0] e_addr;
    build_model();
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      start = (c == bstart_c);
      abort = (c == abort_c);
      if (c == reset_c) begin
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        prev_best = 0;
        prev_dec  = '0;
        start = 1'b0;
        abort = 1'b0;
        return;
      end
      @(negedge clk);
      rw_n += int'(RW_Key_reg);
      de_n += int'(decrement_enable);
      bv_n += int'(bit_valid_o);
      if (done && done_at == 0) done_at = c;
      chk("strobe_overlap", 64'(RW_Key_reg & decrement_enable), 64'd0);
      if (abort_c != 0 && c > abort_c) begin
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_rw", 64'(RW_Key_reg), 64'd0);
        chk("abort_decr", 64'(decrement_enable), 64'd0);
        chk("abort_bit_valid", 64'(bit_valid_o), 64'd0);
        chk("abort_best_hold", 64'(best_state_o), 64'(prev_best));
        chk("abort_decoded_hold", 64'(decoded_o), 64'(prev_dec));
      end else begin
        ab     = (c == abort_c);
        e_rw   = (c == 1) && !ab;
        e_key  = e_rw ? 4'd15 : 4'd0;
        e_de   = (c >= 2) && (c <= 16) && !ab;
        e_bv   = (c >= 18) && (c <= 28) && !ab;
        e_addr = e_bv ? exp_addr[c-18] : '0;
        e_bit  = e_bv ? exp_bit[c-18] : 1'b0;
        e_done = (c == 29) && !ab;
        e_busy = (c <= 29);
        chk("rw_key_reg", 64'(RW_Key_reg), 64'(e_rw));
        chk("key_load_val", 64'(key_Key_reg), 64'(e_key));
        chk("decrement_enable", 64'(decrement_enable), 64'(e_de));
        chk("bit_valid", 64'(bit_valid_o), 64'(e_bv));
        chk("surv_addr", 64'(surv_addr_o), 64'(e_addr));
        chk("bit_o", 64'(bit_o), 64'(e_bit));
        chk("done", 64'(done), 64'(e_done));
        chk("busy", 64'(busy), 64'(e_busy));
        if (c <= 17) begin
          chk("best_hold", 64'(best_state_o), 64'(prev_best));
          chk("decoded_hold", 64'(decoded_o), 64'(prev_dec));
        end else begin
          chk("best_state", 64'(best_state_o), 64'(exp_best));
        end
        if (c >= 29) chk("decoded", 64'(decoded_o), 64'(exp_dec));
      end
    end
    if (abort_c == 0) begin
      chk("rw_pulse_count", 64'(rw_n), 64'd1);
      chk("decr_count", 64'(de_n), 64'd15);
      chk("bit_valid_count", 64'(bv_n), 64'd11);
      chk("done_latency", 64'(done_at), 64'd29);
      prev_best = exp_best;
      prev_dec  = exp_dec;
    end else begin
      chk("abort_no_done", 64'(done_at), 64'd0);
    end
  endtask

  task automatic surv_random();
    for (int a = 0; a < (1 << AW); a++) surv_mem[a] = 1'($urandom_range(0, 1));
  endtask

  task automatic surv_const(input logic v);
    for (int a = 0; a < (1 << AW); a++) surv_mem[a] = v;
  endtask

  initial begin
    for (int i = 0; i < WN; i++) metric_mem[i] = '0;
    surv_const(1'b0);
    #2;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("start_abort_idle_busy", 64'(busy), 64'd0);
    chk("start_abort_idle_rw", 64'(RW_Key_reg), 64'd0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle_busy2", 64'(busy), 64'd0);

    // Minimum search with a stray start during SCAN
    for (int i = 0; i < WN; i++) metric_mem[i] = 32'(100 + i);
    metric_mem[9] = 32'd5;
    surv_random();
    run_pass(0, 0, 8);
    chk("min_search_best_literal", 64'(best_state_o), 64'd9);

    // Ties resolve to the lower index (started back-to-back)
    for (int i = 0; i < WN; i++) metric_mem[i] = 32'd50;
    metric_mem[3]  = 32'd7;
    metric_mem[12] = 32'd7;
    surv_random();
    run_pass(0, 0, 0);
    chk("tie_best_literal", 64'(best_state_o), 64'd3);

    // Traceback from state 4'b1011 with all-zero and all-one survivors
    for (int i = 0; i < WN; i++) metric_mem[i] = 32'd1000;
    metric_mem[11] = 32'd0;
    surv_const(1'b0);
    run_pass(0, 0, 0);
    chk("trace_zero_literal", 64'(decoded_o), 64'h680);
    surv_const(1'b1);
    run_pass(0, 0, 0);
    chk("trace_one_literal", 64'(decoded_o), 64'h6FF);

    // Abort in SCAN cycle 5, then a normal pass
    for (int i = 0; i < WN; i++) metric_mem[i] = $urandom;
    surv_random();
    run_pass(6, 0, 0);
    for (int i = 0; i < WN; i++) metric_mem[i] = $urandom;
    surv_random();
    run_pass(0, 0, 0);

    // Async reset mid-TRACE
    run_pass(0, 22, 0);
    @(negedge clk);
    check_reset_values("reset_hold");
    reset = 1'b1;
    @(negedge clk);

    // Unsigned compare: values with the MSB set must lose
    for (int i = 0; i < WN; i++) metric_mem[i] = 32'h8000_0000 | 32'(i);
    metric_mem[13] = 32'h7FFF_FFFF;
    surv_random();
    run_pass(0, 0, 0);
    chk("unsigned_best_literal", 64'(best_state_o), 64'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
